// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and FSM encoding for the cache miss/fill controller.
package cache_fill_ctrl_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_SIZE   = WORD_SIZE * LINE_WORDS;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    CF_IDLE    = 2'd0,
    CF_FILL    = 2'd1,
    CF_INSTALL = 2'd2,
    CF_WT      = 2'd3
  } cf_state_t;

endpackage

// File: rtl/cache_fill_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/fill controller between a CPU port and a 4-word-line write-through,
// no-allocate cache: read misses fill a whole line, stores always go to memory.
module cache_fill_ctrl #(
  parameter int WORD_W     = cache_fill_ctrl_pkg::WORD_SIZE,
  parameter int LINE_WORDS = cache_fill_ctrl_pkg::LINE_WORDS,
  parameter int TIMEOUT    = cache_fill_ctrl_pkg::TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [WORD_W-1:0]            req_addr,
  input  logic [WORD_W-1:0]            req_wdata,
  output logic                         stall,
  output logic                         done,
  output logic [WORD_W-1:0]            c_addr,
  output logic                         c_readC,
  input  logic                         c_hit,
  output logic                         c_writeC,
  output logic                         c_writeCword,
  output logic [WORD_W*LINE_WORDS-1:0] c_line,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wword,
  input  logic                         mem_ack,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_rline,
  output logic                         err,
  output logic [WORD_W-1:0]            hit_cnt,
  output logic [WORD_W-1:0]            acc_cnt
);

  import cache_fill_ctrl_pkg::*;

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  cf_state_t            state, state_n;
  logic [LINE_W-1:0]    line_q;
  logic                 hit_q;
  logic [WORD_W-1:0]    addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [TMR_W-1:0]     timer;
  logic [WORD_W-1:0]    base_q;

  logic                 latch;
  logic                 timeout;
  logic                 hit_inc;
  logic                 acc_inc;

  // The request is captured on leaving IDLE so a dropped req_valid cannot
  // disturb an in-flight memory transaction.
  assign base_q = {addr_q[WORD_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CF_IDLE;
      line_q  <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) begin
        hit_q   <= c_hit;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        timer   <= '0;
      end else if (((state == CF_FILL) || (state == CF_WT)) && !mem_ack) begin
        timer <= timer + 1'b1;
      end
      if ((state == CF_FILL) && mem_ack) begin
        line_q <= mem_rline;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  // Outputs are held quiet while reset is high so an aborted transaction
  // releases the memory and the pipeline immediately.
  always_comb begin
    state_n      = state;
    stall        = 1'b0;
    done         = 1'b0;
    c_addr       = req_addr;
    c_readC      = 1'b0;
    c_writeC     = 1'b0;
    c_writeCword = 1'b0;
    c_line       = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wword    = '0;
    latch        = 1'b0;
    timeout      = 1'b0;
    hit_inc      = 1'b0;
    acc_inc      = 1'b0;
    if (!reset) begin
      case (state)
        CF_IDLE: begin
          c_readC = req_valid & ~req_write;
          if (req_valid) begin
            if (!req_write && c_hit) begin
              done    = 1'b1;
              hit_inc = 1'b1;
              acc_inc = 1'b1;
            end else begin
              stall   = 1'b1;
              latch   = 1'b1;
              state_n = req_write ? CF_WT : CF_FILL;
            end
          end
        end
        CF_FILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = base_q;
          c_addr   = base_q;
          if (mem_ack) begin
            state_n = CF_INSTALL;
          end else if (timer == TMR_MAX) begin
            timeout = 1'b1;
            mem_req = 1'b0;
            stall   = 1'b0;
            done    = req_valid;
            acc_inc = req_valid;
            state_n = CF_IDLE;
          end
        end
        CF_INSTALL: begin
          stall    = 1'b1;
          c_writeC = 1'b1;
          c_addr   = base_q;
          c_line   = line_q;
          state_n  = CF_IDLE;
        end
        CF_WT: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wword = wdata_q;
          c_addr    = addr_q;
          if (mem_ack) begin
            stall   = 1'b0;
            done    = req_valid;
            acc_inc = req_valid;
            state_n = CF_IDLE;
            // No-allocate: only a store that hit refreshes the cached word.
            if (hit_q) begin
              c_writeCword                = 1'b1;
              c_line[LINE_W-1 -: WORD_W]  = wdata_q;
            end
          end else if (timer == TMR_MAX) begin
            timeout = 1'b1;
            mem_req = 1'b0;
            stall   = 1'b0;
            done    = req_valid;
            acc_inc = req_valid;
            state_n = CF_IDLE;
          end
        end
        default: begin
          state_n = CF_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(WORD_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.WIDTH(WORD_W)) u_acc_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (acc_inc),
    .count (acc_cnt)
  );

endmodule
